seg_display_capture: RTL
========================

Name: seg_display_capture

Overview:
- Receiving end of the multiplexed 7-segment bus (an/seg/dp) driven by the game top.
- Samples the scanned anode/segment lines and decodes each pattern back to a hex nibble, blank or invalid marker.
- Publishes stable 4-digit frames over a valid/ready handshake.
- Used on-board as a display snoop (mirroring digits to logic/LEDs) and in benches as a synthesizable scoreboard front end.

Parameters:
- NDIG, 4, number of multiplexed digits (anode width).
- SETTLE, 3, cycles anode and segments must hold unchanged before a digit is sampled.
- STABLE_FRAMES, 2, consecutive identical captured frames required before publishing.
- FLASH_WINDOW, 2**22, cycles without a blank/non-blank toggle before the flash counter clears (optional feature only).

Ports:
- clkin  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- an_i  in  NDIG  anode selects, active-low.
- seg_i  in  7  segments, active-low; bit0=a .. bit6=g.
- dp_i  in  1  decimal point, active-low.
- digits_o  out  4*NDIG  decoded nibbles; digit0 in [3:0].
- blank_o  out  NDIG  digit was all segments off.
- invalid_o  out  NDIG  pattern not in the decode table.
- dp_o  out  NDIG  decimal point lit per digit.
- frame_valid_o  out  1  published frame pending.
- frame_ready_i  in  1  consumer accepts frame.
- overrun_o  out  1  sticky: a new frame was dropped while one was pending.
- flash_o  out  1  display flashing detected (optional feature).

Behaviour:
- Reset: every output is 0, all shadow/published registers are 0, and the FSM enters COLLECT.
- Input sync: an_i, seg_i and dp_i each pass through a 2-FF synchronizer. All timing below is from the synchronized values.
- Anode validity: exactly one bit low selects that index. Zero or more than one low means no selection; the settle counter is cleared.
- Digit capture:
  - The settle counter increments while the selected index and the seg/dp value are unchanged from the previous cycle; it clears on any change.
  - When the counter equals SETTLE, that slot's shadow entry is written once per dwell, and the slot's bit in the collected mask is set.
- Decode:
  - Standard hex table 0-F; e.g. 0=7'b1000000, 1=7'b1111001, A=7'b0001000, F=7'b0001110.
  - 7'b1111111 gives blank=1 and nibble 0.
  - Any other pattern gives invalid=1 and nibble 0.
  - dp lit = ~dp_i.
- Frame FSM:
  - COLLECT: when the mask is all ones, go to COMPARE and clear the mask.
  - COMPARE (1 cycle):
    - If the shadow frame equals the previous candidate, match_cnt++ (saturating); otherwise match_cnt=1 and the candidate is replaced.
    - If match_cnt reaches STABLE_FRAMES and the candidate differs from the last published frame, go to PUBLISH; otherwise return to COLLECT.
  - PUBLISH: load the output registers, assert frame_valid_o, return to COLLECT. Capture continues during a pending frame.
- Handshake:
  - frame_valid_o holds, with outputs stable, until the cycle frame_valid_o && frame_ready_i; it deasserts the next cycle.
  - A publish while valid is still pending drops the new frame and sets overrun_o (cleared only by reset).
  - A publish in the same cycle as the accept is not an overrun: the new frame loads and valid stays high.
- Identical frames are never republished. The first frame after reset is always published.
- Latency: last digit's settle completes, then 1 cycle COMPARE, then frame_valid_o high on the next edge.
- Reset mid-operation: asynchronous clear of all state; partial frames are discarded.

Optional Feature:
- Macro: DISPLAY_FLASH_DETECT_EN.
- Defined:
  - Each published frame is classified as all-blank or not.
  - A class change versus the prior published frame increments a toggle counter that saturates at 3.
  - A window counter resets on each toggle; reaching FLASH_WINDOW clears the toggle counter.
  - flash_o = (toggle count >= 2).
- Undefined: flash_o is tied 0 and the window/toggle logic is absent.

Decomposition:
- Package seg_display_pkg holds:
  - the seg-to-nibble decode table constants;
  - SEG_BLANK = 7'h7F;
  - the frame FSM state enum (COLLECT, COMPARE, PUBLISH);
  - a frame struct (nibbles, blank, invalid, dp).
- One sub-module, seg_digit_sampler: synchronizer, anode one-hot check, settle counter and per-slot write strobe.

Test Plan:
- Reset and scan: scan 4 digits 1,2,3,A (7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000), each held 10 cycles, 3 full scans -> one frame, digits_o=16'hA321, blank/invalid=0, frame_valid_o after the 2nd identical scan.
- Handshake: hold frame_ready_i=0 and change digit0 to 5 for 3 scans -> frame_valid_o stays high, first frame held, overrun_o=1. Then ready=1 -> valid drops next cycle.
- Glitch/settle: anode dwell of 2 cycles, or two anodes low simultaneously -> no slot captured, no frame published.
- Decode edges: seg=7'h7F on digit2 -> blank_o=4'b0100. seg=7'b1010101 on digit3 -> invalid_o=4'b1000 with nibble 0. dp_i=0 on digit1 -> dp_o=4'b0010.
- Reset mid-frame: assert rst_n=0 after 2 of 4 digits captured -> all outputs 0; the next full stable scan publishes normally.
- Flash (DISPLAY_FLASH_DETECT_EN): alternate all-blank and 16'h0042 frames, 3 stable scans each -> flash_o=1 after the 2nd toggle. Stop toggling for FLASH_WINDOW (reduced to 1000 in the bench) -> flash_o=0.

Source files
------------

// File: rtl/seg_display_capture_pkg.sv
// Shared types and decode table for the 7-segment display capture block.
package seg_display_pkg;

  localparam int PKG_NDIG = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns; entry i occupies bits [i*7 +: 7].
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {
    COLLECT,
    COMPARE,
    PUBLISH
  } frame_state_e;

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       invalid;
  } dig_dec_t;

  typedef struct packed {
    logic [PKG_NDIG*4-1:0] nib;
    logic [PKG_NDIG-1:0]   blank;
    logic [PKG_NDIG-1:0]   invalid;
    logic [PKG_NDIG-1:0]   dp;
  } frame_t;

  function automatic dig_dec_t seg_decode(input logic [6:0] seg);
    dig_dec_t r;
    r = '0;
    if (seg == SEG_BLANK) begin
      r.blank = 1'b1;
    end else begin
      r.invalid = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_TABLE[i*7 +: 7]) begin
          r.nib     = 4'(i);
          r.invalid = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_capture_if.sv
// Published-frame bus of the display capture block: decoded frame plus valid/ready.
interface seg_display_capture_if #(parameter int NDIG = 4);
  logic [4*NDIG-1:0] digits_o;
  logic [NDIG-1:0]   blank_o;
  logic [NDIG-1:0]   invalid_o;
  logic [NDIG-1:0]   dp_o;
  logic              frame_valid_o;
  logic              frame_ready_i;

  modport master (output digits_o, blank_o, invalid_o, dp_o, frame_valid_o,
                  input  frame_ready_i);
  modport slave  (input  digits_o, blank_o, invalid_o, dp_o, frame_valid_o,
                  output frame_ready_i);
endinterface

// File: rtl/seg_display_capture_sampler.sv
// Synchronizes the scanned an/seg/dp lines and strobes one write per settled digit dwell.
module seg_digit_sampler #(
  parameter  int NDIG   = 4,
  parameter  int SETTLE = 3,
  localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int CNT_W  = $clog2(SETTLE + 2)
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic [NDIG-1:0]  an_i,
  input  logic [6:0]       seg_i,
  input  logic             dp_i,
  output logic             wr_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [6:0]       seg_o,
  output logic             dp_lit_o
);

  logic [NDIG-1:0]  an_meta_q, an_sync_q, an_prev_q;
  logic [6:0]       seg_meta_q, seg_sync_q, seg_prev_q;
  logic             dp_meta_q, dp_sync_q, dp_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_vld, changed;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      an_meta_q  <= '0;
      an_sync_q  <= '0;
      an_prev_q  <= '0;
      seg_meta_q <= '0;
      seg_sync_q <= '0;
      seg_prev_q <= '0;
      dp_meta_q  <= 1'b0;
      dp_sync_q  <= 1'b0;
      dp_prev_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      an_meta_q  <= an_i;
      an_sync_q  <= an_meta_q;
      an_prev_q  <= an_sync_q;
      seg_meta_q <= seg_i;
      seg_sync_q <= seg_meta_q;
      seg_prev_q <= seg_sync_q;
      dp_meta_q  <= dp_i;
      dp_sync_q  <= dp_meta_q;
      dp_prev_q  <= dp_sync_q;
      cnt_q      <= cnt_d;
    end
  end

  // Counter runs to SETTLE+1 and parks there, so the strobe fires once per dwell.
  always_comb begin
    sel_vld = $onehot(~an_sync_q);
    idx_o   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_sync_q[i]) idx_o = IDX_W'(i);
    end
    changed = (an_sync_q != an_prev_q) || (seg_sync_q != seg_prev_q) ||
              (dp_sync_q != dp_prev_q);
    cnt_d = cnt_q;
    if (!sel_vld || changed) begin
      cnt_d = '0;
    end else if (cnt_q <= CNT_W'(SETTLE)) begin
      cnt_d = cnt_q + 1'b1;
    end
    wr_o     = sel_vld && !changed && (cnt_q == CNT_W'(SETTLE));
    seg_o    = seg_sync_q;
    dp_lit_o = ~dp_sync_q;
  end

endmodule

// File: rtl/seg_display_capture.sv
// 7-segment bus snoop: rebuilds stable 4-digit frames and publishes them over valid/ready.
// Optional flashing-display detector enabled by defining DISPLAY_FLASH_DETECT_EN.
module seg_display_capture
  import seg_display_pkg::*;
#(
  parameter int NDIG          = PKG_NDIG,
  parameter int SETTLE        = 3,
  parameter int STABLE_FRAMES = 2,
  parameter int FLASH_WINDOW  = 2**22
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic [NDIG-1:0]      an_i,
  input  logic [6:0]           seg_i,
  input  logic                 dp_i,
  seg_display_capture_if.master bus,
  output logic                 overrun_o,
  output logic                 flash_o
);

  localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int MATCH_W = $clog2(STABLE_FRAMES + 1);

  logic             samp_wr, samp_dp;
  logic [IDX_W-1:0] samp_idx;
  logic [6:0]       samp_seg;
  dig_dec_t         dec;

  frame_state_e     state_q, state_d;
  logic [NDIG-1:0]  mask_q, mask_d;
  frame_t           shadow_q, shadow_d, cand_q, cand_d, pub_q, pub_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic             have_pub_q, have_pub_d, valid_q, valid_d, overrun_q, overrun_d;
  logic             pub_load;

  seg_digit_sampler #(.NDIG(NDIG), .SETTLE(SETTLE)) u_sampler (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .an_i     (an_i),
    .seg_i    (seg_i),
    .dp_i     (dp_i),
    .wr_o     (samp_wr),
    .idx_o    (samp_idx),
    .seg_o    (samp_seg),
    .dp_lit_o (samp_dp)
  );

  assign dec      = seg_decode(samp_seg);
  assign pub_load = (state_q == PUBLISH) && (!valid_q || bus.frame_ready_i);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      mask_q     <= '0;
      shadow_q   <= '0;
      cand_q     <= '0;
      pub_q      <= '0;
      match_q    <= '0;
      have_pub_q <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      cand_q     <= cand_d;
      pub_q      <= pub_d;
      match_q    <= match_d;
      have_pub_q <= have_pub_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    cand_d     = cand_q;
    pub_d      = pub_q;
    match_d    = match_q;
    have_pub_d = have_pub_q;
    overrun_d  = overrun_q;
    valid_d    = valid_q && !bus.frame_ready_i;
    mask_d     = (state_q == COLLECT && &mask_q) ? '0 : mask_q;

    if (samp_wr) begin
      shadow_d.nib[samp_idx*4 +: 4] = dec.nib;
      shadow_d.blank[samp_idx]      = dec.blank;
      shadow_d.invalid[samp_idx]    = dec.invalid;
      shadow_d.dp[samp_idx]         = samp_dp;
      mask_d[samp_idx]              = 1'b1;
    end

    case (state_q)
      COLLECT: begin
        if (&mask_q) state_d = COMPARE;
      end
      COMPARE: begin
        if (shadow_q == cand_q) begin
          if (match_q < MATCH_W'(STABLE_FRAMES)) match_d = match_q + 1'b1;
        end else begin
          match_d = MATCH_W'(1);
          cand_d  = shadow_q;
        end
        state_d = (match_d >= MATCH_W'(STABLE_FRAMES) && (!have_pub_q || cand_d != pub_q))
                  ? PUBLISH : COLLECT;
      end
      PUBLISH: begin
        state_d = COLLECT;
        // A frame arriving in the accept cycle replaces the old one; otherwise it is lost.
        if (pub_load) begin
          pub_d      = cand_q;
          have_pub_d = 1'b1;
          valid_d    = 1'b1;
        end else begin
          overrun_d  = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.digits_o      = pub_q.nib;
  assign bus.blank_o       = pub_q.blank;
  assign bus.invalid_o     = pub_q.invalid;
  assign bus.dp_o          = pub_q.dp;
  assign bus.frame_valid_o = valid_q;
  assign overrun_o         = overrun_q;

`ifdef DISPLAY_FLASH_DETECT_EN
  localparam int WIN_W = $clog2(FLASH_WINDOW + 1);

  logic [1:0]       tog_q, tog_d;
  logic             cls_q, cls_d;
  logic [WIN_W-1:0] win_q, win_d;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= '0;
      cls_q <= 1'b0;
      win_q <= '0;
    end else begin
      tog_q <= tog_d;
      cls_q <= cls_d;
      win_q <= win_d;
    end
  end

  // Window restarts on every blank/non-blank class change of a published frame.
  always_comb begin
    tog_d = tog_q;
    cls_d = cls_q;
    win_d = win_q;
    if (win_q == WIN_W'(FLASH_WINDOW)) begin
      tog_d = '0;
    end else begin
      win_d = win_q + 1'b1;
    end
    if (pub_load) begin
      cls_d = &cand_q.blank;
      if (cls_d != cls_q) begin
        win_d = '0;
        tog_d = (tog_q == 2'd3) ? 2'd3 : tog_q + 2'd1;
      end
    end
  end

  assign flash_o = (tog_q >= 2'd2);
`else
  assign flash_o = 1'b0;
`endif

endmodule
